// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout reads win, then the clear engine,
// then a small posted-write FIFO. RAM has a registered address (one-cycle read latency).
module fb_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 4,
    parameter int NUM_WORDS  = 307200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W:0]   LIMIT     = (ADDR_W+1)'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] color_q;
    logic              fill_done_q;
    logic              scan_valid_q;
    logic              scan_ok_q;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic fifo_empty, fifo_full;
    logic push, pop, fill_wr;
    logic scan_in_range, head_in_range;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == FULL_CNT);
    assign wr_ready      = !RESET && !fifo_full;
    assign push          = wr_valid && wr_ready;
    assign head_addr     = fifo_addr_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];
    assign scan_in_range = ({1'b0, scan_addr} < LIMIT);
    assign head_in_range = ({1'b0, head_addr} < LIMIT);

    assign scan_valid = scan_valid_q;
    assign scan_data  = scan_ok_q ? mem_q : '0;
    assign fill_busy  = (state_q == S_FILL);
    assign fill_done  = fill_done_q;

    // Port grant: scanout, then clear engine, then FIFO head.
    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        mem_rden = 1'b0;
        pop      = 1'b0;
        fill_wr  = 1'b0;
        if (!RESET) begin
            if (scan_req) begin
                mem_addr = scan_addr;
                mem_rden = scan_in_range;
            end else if (state_q == S_FILL) begin
                mem_addr = cnt_q;
                mem_data = color_q;
                mem_wren = 1'b1;
                fill_wr  = 1'b1;
            end else if (!fifo_empty) begin
                pop      = 1'b1;
                mem_addr = head_addr;
                mem_data = head_data;
                mem_wren = head_in_range;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (push)
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            color_q      <= '0;
            fill_done_q  <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_ok_q    <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            scan_valid_q <= scan_req;
            scan_ok_q    <= scan_req && scan_in_range;
            fill_done_q  <= 1'b0;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            case (state_q)
                S_IDLE: begin
                    if (fill_start) begin
                        state_q <= S_FILL;
                        cnt_q   <= '0;
                        color_q <= fill_color;
                    end
                end
                S_FILL: begin
                    // Scan cycles stall the counter; it wraps to 0 on the last word.
                    if (fill_wr) begin
                        if (cnt_q == LAST_ADDR) begin
                            state_q     <= S_IDLE;
                            cnt_q       <= '0;
                            fill_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: small framebuffer, behavioural RAM, queue-based reference model.
module tb_fb_arbiter;
    localparam int AW = 8;
    localparam int DW = 4;
    localparam int NW = 64;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scan_req = 1'b0;
    logic [AW-1:0] scan_addr = '0;
    logic          scan_valid;
    logic [DW-1:0] scan_data;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_color = '0;
    logic          fill_busy, fill_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wren, mem_rden;
    logic [DW-1:0] mem_q;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .FIFO_DEPTH(FD)) dut (
        .CLOCK_50(clk), .RESET(rst),
        .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .fill_start(fill_start), .fill_color(fill_color),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        if (mem_rden) mem_q <= ram[mem_addr];
    end

    // Reference model state
    logic [DW-1:0] shadow [256];
    bit            m_fill, m_sv, m_sin, m_done;
    int            m_cnt;
    logic [DW-1:0] m_color, m_sd;
    int            q_addr[$];
    int            q_data[$];

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cycles, done_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
    endtask

    task automatic step();
        int  ea, ed, a, d;
        bit  ew, er, exp_ready, was_fill;
        @(negedge clk);
        exp_ready = !rst && (q_addr.size() < FD);
        chk("wr_ready", wr_ready, exp_ready);
        chk("fill_busy", fill_busy, m_fill);
        chk("fill_done", fill_done, m_done);
        chk("scan_valid", scan_valid, m_sv);
        chk("scan_data", scan_data, (m_sv && m_sin) ? m_sd : 4'd0);
        ea = 0; ed = 0; ew = 0; er = 0;
        if (scan_req) begin
            ea = scan_addr; er = (scan_addr < NW);
        end else if (m_fill) begin
            ea = m_cnt; ed = m_color; ew = 1;
        end else if (q_addr.size() > 0) begin
            ea = q_addr[0]; ed = q_data[0]; ew = (q_addr[0] < NW);
        end
        if (rst) begin ew = 0; er = 0; end
        chk("mem_wren", mem_wren, ew);
        chk("mem_rden", mem_rden, er);
        if (!rst) begin
            chk("mem_addr", mem_addr, ea);
            chk("mem_data", mem_data, ed);
        end
        if (fill_busy) busy_cycles++;
        if (fill_done) done_pulses++;

        if (rst) begin
            m_fill = 0; m_cnt = 0; m_sv = 0; m_sin = 0; m_done = 0;
            q_addr.delete(); q_data.delete();
        end else begin
            was_fill = m_fill;
            m_sv  = scan_req;
            m_sin = scan_req && (scan_addr < NW);
            m_sd  = m_sin ? shadow[scan_addr] : '0;
            m_done = 0;
            if (!scan_req) begin
                if (was_fill) begin
                    shadow[m_cnt] = m_color;
                    if (m_cnt == NW - 1) begin m_fill = 0; m_cnt = 0; m_done = 1; end
                    else m_cnt++;
                end else if (q_addr.size() > 0) begin
                    a = q_addr.pop_front();
                    d = q_data.pop_front();
                    if (a < NW) shadow[a] = DW'(d);
                end
            end
            if (wr_valid && exp_ready) begin
                q_addr.push_back(int'(wr_addr));
                q_data.push_back(int'(wr_data));
            end
            if (!was_fill && fill_start) begin
                m_fill = 1; m_cnt = 0; m_color = fill_color;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        scan_req = 0; wr_valid = 0; fill_start = 0;
    endtask

    initial begin
        int bad, k;
        for (int i = 0; i < 256; i++) begin
            ram[i] = DW'($urandom);
            shadow[i] = ram[i];
        end
        ram[34] = 4'd7; shadow[34] = 4'd7;
        m_fill = 0; m_cnt = 0; m_sv = 0; m_sin = 0; m_done = 0; m_color = '0; m_sd = '0;
        busy_cycles = 0; done_pulses = 0;

        rst = 1;
        @(posedge clk); #1;
        repeat (3) step();
        rst = 0;
        step();
        chk("wr_ready_after_reset", wr_ready, 1'b1);

        // Scan read of a known word
        scan_req = 1; scan_addr = 8'd34;
        step();
        quiet();
        chk("scan34_valid", scan_valid, 1'b1);
        chk("scan34_data", scan_data, 4'd7);
        step();

        // Contention: writes queue up behind a long scan
        scan_req = 1;
        for (int i = 0; i < 10; i++) begin
            scan_addr = AW'($urandom_range(0, NW - 1));
            wr_valid = (i < 4);
            wr_addr = AW'(10 + i);
            wr_data = DW'(1 + i);
            step();
            if (i == 3) chk("wr_ready_full", wr_ready, 1'b0);
        end
        quiet();
        repeat (6) step();
        for (int i = 0; i < 4; i++) chk("contention_order", ram[10 + i], 1 + i);

        // Push+pop with two entries held; same address, last write must win
        scan_req = 1; wr_valid = 1; wr_addr = 8'd20;
        wr_data = 4'd5; step();
        wr_data = 4'd6; step();
        scan_req = 0; wr_data = 4'd7; step();
        chk("pushpop_occupancy", q_addr.size(), 2);
        chk("pushpop_ready", wr_ready, 1'b1);
        quiet();
        repeat (4) step();
        chk("pushpop_order", ram[20], 4'd7);

        // Out-of-range write and scan
        wr_valid = 1; wr_addr = 8'd64; wr_data = 4'd9;
        step();
        quiet();
        step();
        scan_req = 1; scan_addr = 8'd69;
        step();
        quiet();
        chk("oor_scan_valid", scan_valid, 1'b1);
        chk("oor_scan_data", scan_data, 4'd0);
        step();

        // Full clear with scans interleaved every other cycle
        busy_cycles = 0; done_pulses = 0;
        fill_start = 1; fill_color = 4'd3;
        step();
        fill_start = 0;
        k = 0;
        while (m_fill && k < 4 * NW) begin
            scan_req = k[0];
            scan_addr = AW'($urandom_range(0, NW - 1));
            step();
            k++;
        end
        chk("fill_timeout", m_fill, 1'b0);
        quiet();
        repeat (3) step();
        chk("fill_busy_cycles", busy_cycles, 2 * NW - 1);
        chk("fill_done_pulses", done_pulses, 1);
        bad = 0;
        for (int i = 0; i < NW; i++) if (ram[i] !== 4'd3) bad++;
        chk("fill_all_words", bad, 0);

        // Reset in the middle of a fill
        busy_cycles = 0; done_pulses = 0;
        fill_start = 1; fill_color = 4'd5;
        step();
        fill_start = 0;
        k = 0;
        while (m_cnt != 20 && k < 2 * NW) begin step(); k++; end
        chk("fill_reach_20", m_cnt, 20);
        rst = 1;
        step();
        chk("abort_busy", fill_busy, 1'b0);
        rst = 0;
        repeat (4) step();
        chk("abort_no_done", done_pulses, 0);
        bad = 0;
        for (int i = 20; i < NW; i++) if (ram[i] !== 4'd3) bad++;
        chk("abort_untouched", bad, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            scan_req   = ($urandom_range(0, 3) == 0);
            scan_addr  = AW'($urandom_range(0, NW + 8));
            wr_valid   = ($urandom_range(0, 1) == 1);
            wr_addr    = AW'($urandom_range(0, NW + 4));
            wr_data    = DW'($urandom);
            fill_start = ($urandom_range(0, 199) == 0);
            fill_color = DW'($urandom);
            step();
        end
        rst = 0;
        quiet();
        k = 0;
        while ((m_fill || q_addr.size() > 0) && k < 4 * NW) begin step(); k++; end
        repeat (2) step();
        bad = 0;
        for (int i = 0; i < NW; i++) if (ram[i] !== shadow[i]) bad++;
        chk("final_ram_image", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
